// File: rtl/mem_byte_lane.sv
// Load/store alignment unit: word bus transfers, big-endian LBU extract,
// and read-modify-write byte stores with a per-transfer bus timeout.
module mem_byte_lane #(
   parameter int BUS_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [1:0]  cpu_op,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUS_TIMEOUT - 1);

   state_t           r_state;
   logic             r_lbu;
   logic [1:0]       r_off;
   logic [CNT_W-1:0] r_cnt;

   logic [7:0]       w_byte;
   logic [31:0]      w_merge;
   logic             w_tmo;

   // Lane 0 is the most significant byte; SB keeps its byte in bus_wdata[7:0]
   always_comb begin
      w_byte  = bus_rdata[31:24];
      w_merge = bus_rdata;
      unique case (r_off)
         2'd0: begin
            w_byte          = bus_rdata[31:24];
            w_merge[31:24]  = bus_wdata[7:0];
         end
         2'd1: begin
            w_byte          = bus_rdata[23:16];
            w_merge[23:16]  = bus_wdata[7:0];
         end
         2'd2: begin
            w_byte          = bus_rdata[15:8];
            w_merge[15:8]   = bus_wdata[7:0];
         end
         2'd3: begin
            w_byte          = bus_rdata[7:0];
            w_merge[7:0]    = bus_wdata[7:0];
         end
      endcase
   end

   assign w_tmo     = (BUS_TIMEOUT != 0) && (r_cnt == TO_LAST);
   assign cpu_stall = cpu_req & ~cpu_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_lbu     <= 1'b0;
         r_off     <= 2'd0;
         r_cnt     <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wdata <= 32'h0;
         cpu_rdata <= 32'h0;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
      end else begin
         cpu_done <= 1'b0;
         cpu_err  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (cpu_req) begin
                  r_lbu     <= (cpu_op == 2'b01);
                  r_off     <= cpu_addr[1:0];
                  r_cnt     <= '0;
                  bus_addr  <= {cpu_addr[31:2], 2'b00};
                  bus_wdata <= cpu_wdata;
                  bus_req   <= 1'b1;
                  unique case (cpu_op)
                     2'b00, 2'b01: begin
                        bus_we  <= 1'b0;
                        r_state <= S_RD;
                     end
                     2'b10: begin
                        bus_we  <= 1'b1;
                        r_state <= S_WR;
                     end
                     2'b11: begin
                        bus_we  <= 1'b0;
                        r_state <= S_RMW_RD;
                     end
                  endcase
               end
            end
            S_RD, S_WR, S_RMW_RD, S_RMW_WR: begin
               if (bus_ready) begin
                  r_cnt <= '0;
                  if (r_state == S_RMW_RD) begin
                     bus_wdata <= w_merge;
                     bus_we    <= 1'b1;
                     r_state   <= S_RMW_WR;
                  end else begin
                     if (r_state == S_RD)
                        cpu_rdata <= r_lbu ? {24'h0, w_byte} : bus_rdata;
                     bus_req  <= 1'b0;
                     bus_we   <= 1'b0;
                     cpu_done <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end else if (w_tmo) begin
                  r_cnt    <= '0;
                  bus_req  <= 1'b0;
                  bus_we   <= 1'b0;
                  cpu_done <= 1'b1;
                  cpu_err  <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_byte_lane.sv
// Scoreboard bench for mem_byte_lane: memory-backed bus responder,
// high-level load/store reference model, randomized ops and delays.
module tb_mem_byte_lane;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [1:0]  cpu_op;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        cpu_done;
   logic        cpu_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   mem_byte_lane #(.BUS_TIMEOUT(TO), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_op    (cpu_op),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .cpu_done  (cpu_done),
      .cpu_err   (cpu_err),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ready (bus_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          dly;
   } xfer_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          start;
   } exp_t;

   xfer_t xq[$];
   exp_t  eq[$];

   logic [31:0] bus_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] words [8];
   logic [31:0] ref_last;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int wr_cnt = 0;
   logic [31:0] last_wr_addr = 32'h0;
   logic [31:0] last_wr_data = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Bus side: memory with a per-transfer wait count taken from xq
   initial begin
      xfer_t cur;
      int    left;
      bit    active;
      bus_ready = 1'b0;
      bus_rdata = 32'h0;
      active    = 1'b0;
      left      = 0;
      forever begin
         @(negedge clk);
         if (!bus_req) begin
            active    = 1'b0;
            bus_ready = ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
         end else begin
            if (!active) begin
               if (xq.size() == 0) begin
                  errors++;
                  $display("FAIL bus_unexpected: addr %h we %b", bus_addr, bus_we);
               end else begin
                  cur    = xq.pop_front();
                  left   = cur.dly;
                  active = 1'b1;
               end
            end
            if (active) begin
               checks++;
               if (bus_addr !== cur.addr || bus_we !== cur.we ||
                   (cur.we && bus_wdata !== cur.wdata)) begin
                  errors++;
                  $display("FAIL bus_xfer: got a=%h we=%b d=%h expected a=%h we=%b d=%h",
                           bus_addr, bus_we, bus_wdata, cur.addr, cur.we, cur.wdata);
               end
               if (left == 0) begin
                  bus_ready = 1'b1;
                  if (bus_we) begin
                     bus_mem[bus_addr] = bus_wdata;
                     wr_cnt++;
                     last_wr_addr = bus_addr;
                     last_wr_data = bus_wdata;
                  end else begin
                     bus_rdata = bus_mem[bus_addr];
                  end
                  active = 1'b0;
               end else begin
                  bus_ready = 1'b0;
                  bus_rdata = $urandom;
                  left--;
               end
            end else begin
               bus_ready = 1'b0;
            end
         end
      end
   end

   // Completion monitor
   initial begin
      exp_t e;
      int   lat;
      forever begin
         @(negedge clk);
         if (cpu_done) begin
            checks++;
            if (eq.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: rdata %h err %b", cpu_rdata, cpu_err);
            end else begin
               e   = eq.pop_front();
               lat = cyc - e.start + 1;
               if (cpu_rdata !== e.rdata || cpu_err !== e.err || lat != e.lat) begin
                  errors++;
                  $display("FAIL completion: got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                           cpu_rdata, cpu_err, lat, e.rdata, e.err, e.lat);
               end
            end
         end else if (!rst) begin
            checks++;
            if (cpu_err !== 1'b0) begin
               errors++;
               $display("FAIL err_idle: got %b expected 0", cpu_err);
            end
         end
      end
   end

   function automatic int rnd_dly();
      if ($urandom_range(0, 7) == 0) return TO + $urandom_range(0, 1);
      return $urandom_range(0, 3);
   endfunction

   function automatic logic [31:0] lane_sh(input logic [31:0] v, input int off);
      return v >> (8 * (3 - off));
   endfunction

   // Reference model plus drive of one operation through to cpu_done
   task automatic do_txn(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int d1, input int d2);
      logic [31:0] word, v, m;
      int          off, sh, lat;
      logic        err;
      bit          got;
      word = {addr[31:2], 2'b00};
      off  = int'(addr[1:0]);
      sh   = 8 * (3 - off);
      err  = 1'b0;
      v    = ref_mem[word];
      xq.push_back('{word, (op == 2'b10), wd, d1});
      if (d1 >= TO) begin
         err = 1'b1;
         lat = 2 + TO;
      end else if (op == 2'b11) begin
         m = (v & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
         xq.push_back('{word, 1'b1, m, d2});
         if (d2 >= TO) begin
            err = 1'b1;
            lat = 3 + d1 + TO;
         end else begin
            ref_mem[word] = m;
            lat = 4 + d1 + d2;
         end
      end else begin
         lat = 3 + d1;
         if (op == 2'b00) ref_last = v;
         if (op == 2'b01) ref_last = lane_sh(v, off) & 32'hFF;
         if (op == 2'b10) ref_mem[word] = wd;
      end
      @(negedge clk);
      eq.push_back('{ref_last, err, lat, cyc});
      cpu_req   = 1'b1;
      cpu_op    = op;
      cpu_addr  = addr;
      cpu_wdata = wd;
      #1;
      chk("stall_req", {31'h0, cpu_stall}, 32'h1);
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (cpu_done) begin
            got = 1'b1;
            chk("stall_done", {31'h0, cpu_stall}, 32'h0);
         end else begin
            chk("stall_wait", {31'h0, cpu_stall}, 32'h1);
         end
      end
      if (!got) begin
         errors++;
         $display("FAIL done_timeout: op %0d addr %h no cpu_done in 40 cycles", op, addr);
      end
      cpu_req = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m0;
      int          w0;
      words = '{32'h100, 32'h104, 32'h200, 32'h204,
                32'h300, 32'h304, 32'h400, 32'h404};
      foreach (words[i]) begin
         m0 = $urandom;
         bus_mem[words[i]] = m0;
         ref_mem[words[i]] = m0;
      end
      ref_last  = 32'h0;
      rst       = 1'b1;
      cpu_req   = 1'b0;
      cpu_op    = 2'b00;
      cpu_addr  = 32'h0;
      cpu_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
      chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
      chk("rst_done", {31'h0, cpu_done}, 32'h0);
      chk("rst_err", {31'h0, cpu_err}, 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
      rst = 1'b0;

      bus_mem[32'h100] = 32'hA1B2C3D4;
      ref_mem[32'h100] = 32'hA1B2C3D4;
      do_txn(2'b01, 32'h102, 32'h0, 0, 0);
      chk("lbu_off2", cpu_rdata, 32'h000000C3);
      do_txn(2'b01, 32'h100, 32'h0, 0, 0);
      chk("lbu_off0", cpu_rdata, 32'h000000A1);
      do_txn(2'b01, 32'h101, 32'h0, 0, 0);
      chk("lbu_off1", cpu_rdata, 32'h000000B2);
      do_txn(2'b01, 32'h103, 32'h0, 0, 0);
      chk("lbu_off3", cpu_rdata, 32'h000000D4);

      bus_mem[32'h200] = 32'h11223344;
      ref_mem[32'h200] = 32'h11223344;
      w0 = wr_cnt;
      do_txn(2'b11, 32'h201, 32'hFFFFFF5A, 0, 0);
      chk("sb_wr_addr", last_wr_addr, 32'h200);
      chk("sb_wr_data", last_wr_data, 32'h115A3344);
      chk("sb_wr_count", wr_cnt - w0, 32'd1);
      chk("sb_rdata_hold", cpu_rdata, 32'h000000D4);

      bus_mem[32'h104] = 32'hDEADBEEF;
      ref_mem[32'h104] = 32'hDEADBEEF;
      do_txn(2'b00, 32'h104, 32'h0, 3, 0);
      chk("lw_delayed", cpu_rdata, 32'hDEADBEEF);

      do_txn(2'b10, 32'h303, 32'h12345678, 0, 0);
      chk("sw_addr", last_wr_addr, 32'h300);
      chk("sw_data", last_wr_data, 32'h12345678);

      w0 = wr_cnt;
      do_txn(2'b11, 32'h204, 32'h0000009C, TO, 0);
      chk("sb_tmo_nowrite", wr_cnt - w0, 32'd0);
      @(negedge clk);
      chk("sb_tmo_idle", {31'h0, bus_req}, 32'h0);

      // Reset in the write half of a byte store
      w0 = wr_cnt;
      m0 = bus_mem[32'h200];
      xq.push_back('{32'h200, 1'b0, 32'h0, 0});
      xq.push_back('{32'h200, 1'b1,
                     (ref_mem[32'h200] & 32'hFF00FFFF) | 32'h00770000, 3});
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_op    = 2'b11;
      cpu_addr  = 32'h201;
      cpu_wdata = 32'h77;
      repeat (2) @(negedge clk);
      chk("rmw_wr_phase", {30'h0, bus_req, bus_we}, 32'h3);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req", {31'h0, bus_req}, 32'h0);
      chk("rst_mid_done", {31'h0, cpu_done}, 32'h0);
      chk("rst_mid_rdata", cpu_rdata, 32'h0);
      rst     = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("rst_mid_nowrite", wr_cnt - w0, 32'd0);
      chk("rst_mid_mem", bus_mem[32'h200], m0);
      xq.delete();
      ref_last = 32'h0;
      do_txn(2'b01, 32'h202, 32'h0, 1, 0);
      chk("lbu_after_rst", cpu_rdata, {24'h0, m0[15:8]});

      for (int t = 0; t < 300; t++) begin
         do_txn(2'($urandom_range(0, 3)),
                words[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
                $urandom, rnd_dly(), rnd_dly());
      end

      repeat (4) @(negedge clk);
      foreach (words[i]) chk("mem_final", bus_mem[words[i]], ref_mem[words[i]]);
      chk("eq_empty", eq.size(), 32'd0);
      chk("xq_empty", xq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
